// File: rtl/object_bbox.sv
// object_bbox
//
// Purpose:
//   Takes the binary motion mask from the delta-frame stage, one pixel per
//   clock in raster order, and measures the moving object once per frame.
//   Isolated foreground specks are rejected by a horizontal run-length
//   qualifier. The block accumulates the bounding box, the qualified-pixel
//   count and the box centre. It publishes the result with a single-cycle
//   bbox_valid pulse two cycles after frame_end.
//
// Ports:
//   clk          clock
//   aresetn      asynchronous active-low reset
//   is_not_blank 1 = active-video pixel this cycle
//   x_pos        column of the current pixel
//   y_pos        row of the current pixel
//   pixel_in     mask pixel, nonzero = foreground
//   frame_end    single-cycle pulse in vertical blanking after the last pixel
//   bbox_valid   single-cycle pulse when the result outputs update
//   obj_found    qualified count of the last frame >= MIN_PIXELS
//   x_min/x_max/y_min/y_max  bounding box (0 when no object was found)
//   x_center/y_center        (min+max)>>1 (0 when no object was found)
//   fg_count     qualified-pixel count of the last frame (always reported)

module object_bbox #(
  parameter int INPUT_WIDTH = 10,
  parameter int DISP_WIDTH  = 11,
  parameter int RUN_LENGTH  = 4,
  parameter int MIN_PIXELS  = 64,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   is_not_blank,
  input  logic [DISP_WIDTH-1:0]  x_pos,
  input  logic [DISP_WIDTH-1:0]  y_pos,
  input  logic [INPUT_WIDTH-1:0] pixel_in,
  input  logic                   frame_end,
  output logic                   bbox_valid,
  output logic                   obj_found,
  output logic [DISP_WIDTH-1:0]  x_min,
  output logic [DISP_WIDTH-1:0]  x_max,
  output logic [DISP_WIDTH-1:0]  y_min,
  output logic [DISP_WIDTH-1:0]  y_max,
  output logic [DISP_WIDTH-1:0]  x_center,
  output logic [DISP_WIDTH-1:0]  y_center,
  output logic [COUNT_WIDTH-1:0] fg_count
);

  localparam logic [3:0]             RUN_MAX  = 4'(RUN_LENGTH);
  localparam logic [3:0]             RUN_QUAL = 4'(RUN_LENGTH - 1);
  localparam logic [DISP_WIDTH-1:0]  LEAD     = DISP_WIDTH'(RUN_LENGTH - 1);
  localparam logic [COUNT_WIDTH-1:0] MIN_CNT  = COUNT_WIDTH'(MIN_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_LATCH,
    S_OUTPUT
  } state_t;

  state_t state, next_state;

  logic                   fg;
  logic                   qual;
  logic [3:0]             run_cnt;
  logic [DISP_WIDTH-1:0]  left_x;

  logic                   acc_clear;
  logic                   acc_en;
  logic                   snap_load;
  logic                   out_load;

  logic [DISP_WIDTH-1:0]  acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [COUNT_WIDTH-1:0] acc_cnt;
  logic [DISP_WIDTH-1:0]  snap_xmin, snap_xmax, snap_ymin, snap_ymax;
  logic [COUNT_WIDTH-1:0] snap_cnt;

  logic [DISP_WIDTH:0]    x_sum, y_sum;
  logic                   snap_found;

  assign fg   = is_not_blank && (pixel_in != '0);
  // The run counter value is taken before this pixel's increment, so the
  // RUN_LENGTH-th consecutive foreground pixel is the first to qualify.
  assign qual = fg && (run_cnt >= RUN_QUAL);
  // A qualifying pixel implies RUN_LENGTH-1 foreground pixels to its left,
  // so the left edge of the box is pulled back to the start of the run.
  assign left_x = x_pos - LEAD;

  // Horizontal run counter: saturates at RUN_LENGTH, and any background or
  // blanking pixel clears it, so a run can never continue onto the next line.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      run_cnt <= '0;
    end else if (fg) begin
      if (run_cnt < RUN_MAX) run_cnt <= run_cnt + 4'd1;
    end else begin
      run_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= next_state;
  end

  // Frame sequencing. IDLE throws away the partial frame seen after reset.
  // On frame_end in ACCUM the totals are snapshotted and the accumulators
  // restart in the same cycle, so the next frame is collected while LATCH
  // and OUTPUT publish the previous one. A qualified pixel that arrives
  // together with frame_end is dropped from both frames. frame_end seen in
  // LATCH/OUTPUT is ignored.
  always_comb begin
    next_state = state;
    acc_clear  = 1'b0;
    acc_en     = 1'b0;
    snap_load  = 1'b0;
    out_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_end) begin
          acc_clear  = 1'b1;
          next_state = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (frame_end) begin
          snap_load  = 1'b1;
          acc_clear  = 1'b1;
          next_state = S_LATCH;
        end else begin
          acc_en = qual;
        end
      end
      S_LATCH: begin
        acc_en     = qual;
        out_load   = 1'b1;
        next_state = S_OUTPUT;
      end
      S_OUTPUT: begin
        acc_en     = qual;
        next_state = S_ACCUM;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Running extremes and count for the frame in progress. The clear values
  // (min = all ones, max = 0) let the first qualified pixel set every bound.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (acc_clear) begin
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (acc_en) begin
      if (left_x < acc_xmin) acc_xmin <= left_x;
      if (x_pos > acc_xmax)  acc_xmax <= x_pos;
      if (y_pos < acc_ymin)  acc_ymin <= y_pos;
      if (y_pos > acc_ymax)  acc_ymax <= y_pos;
      if (acc_cnt != '1)     acc_cnt  <= acc_cnt + 1'b1;
    end
  end

  // Shadow copy of the finished frame. The accumulators are already busy
  // with the next frame while this copy is published.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      snap_xmin <= '0;
      snap_xmax <= '0;
      snap_ymin <= '0;
      snap_ymax <= '0;
      snap_cnt  <= '0;
    end else if (snap_load) begin
      snap_xmin <= acc_xmin;
      snap_xmax <= acc_xmax;
      snap_ymin <= acc_ymin;
      snap_ymax <= acc_ymax;
      snap_cnt  <= acc_cnt;
    end
  end

  // Centres use one extra bit so min+max cannot overflow before the halving.
  assign x_sum      = {1'b0, snap_xmin} + {1'b0, snap_xmax};
  assign y_sum      = {1'b0, snap_ymin} + {1'b0, snap_ymax};
  assign snap_found = (snap_cnt >= MIN_CNT);

  // The result registers load at the end of LATCH. bbox_valid is therefore
  // high during OUTPUT, two cycles after frame_end, together with the new
  // values. Coordinates are forced to 0 when no object qualified, but the
  // true count is always reported.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bbox_valid <= 1'b0;
      obj_found  <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      x_center   <= '0;
      y_center   <= '0;
      fg_count   <= '0;
    end else begin
      bbox_valid <= out_load;
      if (out_load) begin
        obj_found <= snap_found;
        fg_count  <= snap_cnt;
        if (snap_found) begin
          x_min    <= snap_xmin;
          x_max    <= snap_xmax;
          y_min    <= snap_ymin;
          y_max    <= snap_ymax;
          x_center <= DISP_WIDTH'(x_sum >> 1);
          y_center <= DISP_WIDTH'(y_sum >> 1);
        end else begin
          x_min    <= '0;
          x_max    <= '0;
          y_min    <= '0;
          y_max    <= '0;
          x_center <= '0;
          y_center <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_object_bbox.sv
// tb_object_bbox
//
// Purpose:
//   Self-checking bench for object_bbox. Each frame_end that should produce
//   a result pushes the expected outputs and the expected bbox_valid cycle
//   onto a queue. A monitor pops an entry on every bbox_valid pulse and
//   compares it. Scenario tasks also check reset values and the frames that
//   must not produce a pulse.
//
// Ports: none (top-level bench).

module tb_object_bbox;

  logic        clk;
  logic        aresetn;
  logic        is_not_blank;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic [9:0]  pixel_in;
  logic        frame_end;
  logic        bbox_valid;
  logic        obj_found;
  logic [10:0] x_min, x_max, y_min, y_max, x_center, y_center;
  logic [19:0] fg_count;

  typedef struct {
    logic        found;
    logic [10:0] xmin, xmax, ymin, ymax, xc, yc;
    logic [19:0] cnt;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   valid_count = 0;
  int   cyc         = 0;

  object_bbox #(
    .INPUT_WIDTH(10), .DISP_WIDTH(11), .RUN_LENGTH(4),
    .MIN_PIXELS(64), .COUNT_WIDTH(20)
  ) dut (
    .clk(clk), .aresetn(aresetn), .is_not_blank(is_not_blank),
    .x_pos(x_pos), .y_pos(y_pos), .pixel_in(pixel_in), .frame_end(frame_end),
    .bbox_valid(bbox_valid), .obj_found(obj_found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .x_center(x_center), .y_center(y_center), .fg_count(fg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every bbox_valid pulse must match the oldest expectation,
  // both in timing and in content. A pulse with nothing queued is an error.
  always @(negedge clk) begin
    if (aresetn === 1'b1 && bbox_valid === 1'b1) begin
      exp_t e;
      logic [86:0] act, req;
      valid_count++;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_valid: bbox_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q.pop_front();
        if (cyc !== e.cyc) begin
          miscompares++;
          $display("[TB] FAIL valid_latency: pulse at cycle %0d, required %0d", cyc, e.cyc);
        end
        vectors++;
        act = {obj_found, x_min, x_max, y_min, y_max, x_center, y_center, fg_count};
        req = {e.found, e.xmin, e.xmax, e.ymin, e.ymax, e.xc, e.yc, e.cnt};
        if (act !== req) begin
          miscompares++;
          $display("[TB] FAIL bbox_result: got found=%0d box=%0d..%0d,%0d..%0d ctr=%0d,%0d cnt=%0d required found=%0d box=%0d..%0d,%0d..%0d ctr=%0d,%0d cnt=%0d",
                   obj_found, x_min, x_max, y_min, y_max, x_center, y_center, fg_count,
                   e.found, e.xmin, e.xmax, e.ymin, e.ymax, e.xc, e.yc, e.cnt);
        end
      end
    end
  end

  function automatic exp_t mk(input bit f, input int xmn, input int xmx, input int ymn,
                              input int ymx, input int xc, input int yc, input int cnt);
    exp_t e;
    e.found = f;
    e.xmin = 11'(xmn); e.xmax = 11'(xmx); e.ymin = 11'(ymn); e.ymax = 11'(ymx);
    e.xc = 11'(xc); e.yc = 11'(yc); e.cnt = 20'(cnt); e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t zero_box(input int cnt);
    return mk(1'b0, 0, 0, 0, 0, 0, 0, cnt);
  endfunction

  // Called in the same time step in which frame_end is driven: the pulse is
  // due two rising edges later.
  task automatic push_exp(input exp_t e);
    e.cyc = cyc + 2;
    q.push_back(e);
  endtask

  task automatic drive_pix(input int x, input int y, input bit act, input bit f, input bit fe);
    @(negedge clk);
    is_not_blank = act;
    x_pos        = 11'(x);
    y_pos        = 11'(y);
    pixel_in     = f ? 10'((x % 1023) + 1) : 10'd0;
    frame_end    = fe;
  endtask

  task automatic drive_row(input int y, input int xs, input int xe, input int fg_lo, input int fg_hi);
    for (int x = xs; x <= xe; x++) drive_pix(x, y, 1'b1, (x >= fg_lo && x <= fg_hi), 1'b0);
    drive_pix(0, y, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rect_frame(input int ylo, input int yhi, input int xs, input int xe,
                            input int fg_lo, input int fg_hi);
    for (int y = ylo; y <= yhi; y++) drive_row(y, xs, xe, fg_lo, fg_hi);
  endtask

  // Pulse frame_end in blanking and wait, bounded, for the expected result.
  task automatic end_frame(input bit expect_out, input exp_t e);
    drive_pix(0, 0, 1'b0, 1'b0, 1'b1);
    if (expect_out) push_exp(e);
    drive_pix(0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL valid_timeout: %0d results still pending, required 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [86:0] act;
    #1;
    act = {bbox_valid, x_min, x_max, y_min, y_max, x_center, y_center, fg_count};
    vectors++;
    if (act !== '0 || obj_found !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, required 0", act);
    end
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic test_rectangle();
    int vc;
    vc = valid_count;
    end_frame(1'b0, zero_box(0));
    vectors++;
    if (valid_count !== vc) begin
      miscompares++;
      $display("[TB] FAIL idle_frame_end: %0d pulses, required 0", valid_count - vc);
    end
    rect_frame(50, 59, 96, 123, 100, 119);
    end_frame(1'b1, mk(1'b1, 100, 119, 50, 59, 109, 54, 170));
  endtask

  task automatic test_short_runs();
    for (int y = 100; y < 120; y++) begin
      for (int x = 20; x < 60; x++) drive_pix(x, y, 1'b1, ((x - 20) % 4) != 3, 1'b0);
      drive_pix(0, y, 1'b0, 1'b0, 1'b0);
    end
    end_frame(1'b1, zero_box(0));
  endtask

  task automatic test_small_square();
    rect_frame(10, 17, 8, 20, 10, 17);
    end_frame(1'b1, zero_box(40));
  endtask

  task automatic test_line_boundary();
    drive_row(20, 630, 639, 637, 639);
    drive_row(21, 0, 9, 0, 0);
    end_frame(1'b1, zero_box(0));
  endtask

  task automatic test_min_pixels();
    rect_frame(70, 73, 196, 222, 200, 218);
    end_frame(1'b1, mk(1'b1, 200, 218, 70, 73, 209, 71, 64));
    rect_frame(70, 72, 196, 222, 200, 218);
    drive_row(73, 196, 222, 200, 217);
    end_frame(1'b1, zero_box(63));
  endtask

  // frame_end lands on a qualified pixel (dropped) and is held one extra
  // cycle into LATCH (ignored). The run carries on, so LATCH/OUTPUT pixels
  // belong to the next frame.
  task automatic test_back_to_back();
    rect_frame(30, 32, 296, 323, 300, 319);
    for (int x = 296; x <= 330; x++) begin
      drive_pix(x, 33, 1'b1, x >= 300, (x == 319 || x == 320));
      if (x == 319) push_exp(mk(1'b1, 300, 319, 30, 33, 309, 31, 67));
    end
    drive_pix(0, 33, 1'b0, 1'b0, 1'b0);
    rect_frame(60, 64, 496, 523, 500, 519);
    end_frame(1'b1, mk(1'b1, 317, 519, 33, 64, 418, 48, 96));
  endtask

  task automatic test_first_frame_discard();
    int vc;
    @(negedge clk);
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    rect_frame(50, 59, 96, 123, 100, 119);
    vc = valid_count;
    end_frame(1'b0, zero_box(0));
    vectors++;
    if (valid_count !== vc) begin
      miscompares++;
      $display("[TB] FAIL discard_first_frame: %0d pulses, required 0", valid_count - vc);
    end
    rect_frame(50, 59, 96, 123, 100, 119);
    end_frame(1'b1, mk(1'b1, 100, 119, 50, 59, 109, 54, 170));
  endtask

  task automatic test_reset_mid_frame();
    logic [86:0] act;
    int vc;
    rect_frame(50, 54, 96, 123, 100, 119);
    for (int x = 96; x < 110; x++) drive_pix(x, 55, 1'b1, x >= 100, 1'b0);
    @(negedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    act = {bbox_valid, x_min, x_max, y_min, y_max, x_center, y_center, fg_count};
    vectors++;
    if (act !== '0 || obj_found !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_outputs: got %h, required 0", act);
    end
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    rect_frame(56, 59, 96, 123, 100, 119);
    vc = valid_count;
    end_frame(1'b0, zero_box(0));
    vectors++;
    if (valid_count !== vc) begin
      miscompares++;
      $display("[TB] FAIL reset_returns_idle: %0d pulses, required 0", valid_count - vc);
    end
    rect_frame(50, 59, 96, 123, 100, 119);
    end_frame(1'b1, mk(1'b1, 100, 119, 50, 59, 109, 54, 170));
  endtask

  initial begin
    aresetn      = 1'b0;
    is_not_blank = 1'b0;
    x_pos        = '0;
    y_pos        = '0;
    pixel_in     = '0;
    frame_end    = 1'b0;
    test_reset();
    test_rectangle();
    test_short_runs();
    test_small_square();
    test_line_boundary();
    test_min_pixels();
    test_back_to_back();
    test_first_frame_discard();
    test_reset_mid_frame();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL leftover_expectations: %0d pending, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
